// File: rtl/sbox_share_ctrl.sv
// Shared AES Sbox bank: SubBytes for 128-bit states, SubWord for 32-bit key words.
// Latency: state job responds P+1 cycles after accept, key job 2 cycles after accept.
// Backpressure: requests are accepted only when idle; responses are one-cycle strobes with no backpressure.
module sbox_share_ctrl #(
  parameter int LANES        = 4,
  parameter bit KEY_PRIORITY = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic [127:0] st_data,
  output logic         st_resp_valid,
  output logic [127:0] st_resp_data,
  input  logic         key_req_valid,
  output logic         key_req_ready,
  input  logic [31:0]  key_word,
  output logic         key_resp_valid,
  output logic [31:0]  key_resp_word,
  output logic         busy
);

  localparam int P  = 16 / LANES;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam logic [PW-1:0] LAST_PASS = PW'(P - 1);

  // FIPS-197 forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SBOX_TABLE[idx +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, ST_RUN, KEY_RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pass, pass_nxt;
  logic          last_key;   // last grant went to the key requester
  logic          job_key;    // current job is a key word
  logic [127:0]  work;       // input bytes, replaced in place by Sbox results
  logic [127:0]  work_nxt;
  logic [7:0]    lane_in  [LANES];
  logic [7:0]    lane_out [LANES];
  logic          idle_open, st_acc, key_acc;

  // With two requesters, "preferred unless it had the last grant" is strict
  // alternation; the preference only shows through the reset value of last_key.
  assign idle_open     = (state == IDLE) && !clr;
  assign st_req_ready  = idle_open && st_req_valid  && (!key_req_valid || last_key);
  assign key_req_ready = idle_open && key_req_valid && (!st_req_valid  || !last_key);
  assign st_acc        = st_req_valid  && st_req_ready;
  assign key_acc       = key_req_valid && key_req_ready;

  assign busy           = (state != IDLE);
  assign st_resp_valid  = (state == DONE) && !job_key;
  assign key_resp_valid = (state == DONE) && job_key;

  // Lane l takes byte pass*LANES+l; a key word sits in bytes 0..3 so pass 0 serves it.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = 8'h00;
      for (int q = 0; q < P; q++) begin
        if (pass == PW'(q)) lane_in[l] = work[127-8*(q*LANES+l) -: 8];
      end
      lane_out[l] = sbox(lane_in[l]);
    end
  end

  // Merge this pass's lane results back into their byte positions.
  always_comb begin
    work_nxt = work;
    for (int i = 0; i < 16; i++) begin
      if ((state == ST_RUN) && (pass == PW'(i / LANES))) work_nxt[127-8*i -: 8] = lane_out[i % LANES];
    end
  end

  // Next-state and pass counter; clr overrides everything.
  always_comb begin
    state_nxt = state;
    pass_nxt  = pass;
    case (state)
      IDLE: begin
        if (st_acc) begin
          state_nxt = ST_RUN;
          pass_nxt  = '0;
        end else if (key_acc) begin
          state_nxt = KEY_RUN;
        end
      end
      ST_RUN: begin
        if (pass == LAST_PASS) begin
          state_nxt = DONE;
          pass_nxt  = '0;
        end else begin
          pass_nxt = pass + 1'b1;
        end
      end
      KEY_RUN: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) begin
      state_nxt = IDLE;
      pass_nxt  = '0;
    end
  end

  // State register and pass counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pass  <= '0;
    end else begin
      state <= state_nxt;
      pass  <= pass_nxt;
    end
  end

  // Job capture, in-place substitution, and response registers loaded only on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work          <= '0;
      last_key      <= ~KEY_PRIORITY;
      job_key       <= 1'b0;
      st_resp_data  <= '0;
      key_resp_word <= '0;
    end else begin
      if (st_acc) begin
        work     <= st_data;
        last_key <= 1'b0;
        job_key  <= 1'b0;
      end else if (key_acc) begin
        work[127:96] <= key_word;
        last_key     <= 1'b1;
        job_key      <= 1'b1;
      end else if ((state == ST_RUN) && !clr) begin
        work <= work_nxt;
      end
      if ((state == ST_RUN) && (pass == LAST_PASS) && !clr) st_resp_data <= work_nxt;
      if ((state == KEY_RUN) && !clr) key_resp_word <= {lane_out[0], lane_out[1], lane_out[2], lane_out[3]};
    end
  end

endmodule

// File: tb/tb_sbox_share_ctrl.sv
module tb_sbox_share_ctrl;

  localparam logic [127:0] VEC_IN  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] VEC_OUT = 128'h63cab7040953d051cd60e0e7ba70e18c;
  localparam logic [127:0] ALL00   = 128'h0;
  localparam logic [127:0] ALL63   = {16{8'h63}};
  localparam logic [127:0] ALLFF   = {16{8'hff}};
  localparam logic [127:0] ALL16   = {16{8'h16}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, clr, st_req_valid, key_req_valid, v_st_valid;
  logic [127:0] st_data;
  logic [31:0]  key_word;
  logic         st_req_ready, st_resp_valid, key_req_ready, key_resp_valid, busy;
  logic [127:0] st_resp_data;
  logic [31:0]  key_resp_word;
  logic         v8_st_rdy, v8_st_vld, v8_key_rdy, v8_key_vld, v8_busy;
  logic [127:0] v8_st_dat;
  logic [31:0]  v8_key_dat;
  logic         v16_st_rdy, v16_st_vld, v16_key_rdy, v16_key_vld, v16_busy;
  logic [127:0] v16_st_dat;
  logic [31:0]  v16_key_dat;

  int checks = 0;
  int failures = 0;

  sbox_share_ctrl #(.LANES(4), .KEY_PRIORITY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_data(st_data),
    .st_resp_valid(st_resp_valid), .st_resp_data(st_resp_data),
    .key_req_valid(key_req_valid), .key_req_ready(key_req_ready), .key_word(key_word),
    .key_resp_valid(key_resp_valid), .key_resp_word(key_resp_word), .busy(busy));

  sbox_share_ctrl #(.LANES(8), .KEY_PRIORITY(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0),
    .st_req_valid(v_st_valid), .st_req_ready(v8_st_rdy), .st_data(st_data),
    .st_resp_valid(v8_st_vld), .st_resp_data(v8_st_dat),
    .key_req_valid(1'b0), .key_req_ready(v8_key_rdy), .key_word(32'h0),
    .key_resp_valid(v8_key_vld), .key_resp_word(v8_key_dat), .busy(v8_busy));

  sbox_share_ctrl #(.LANES(16), .KEY_PRIORITY(1'b1)) dut16 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0),
    .st_req_valid(v_st_valid), .st_req_ready(v16_st_rdy), .st_data(st_data),
    .st_resp_valid(v16_st_vld), .st_resp_data(v16_st_dat),
    .key_req_valid(1'b0), .key_req_ready(v16_key_rdy), .key_word(32'h0),
    .key_resp_valid(v16_key_vld), .key_resp_word(v16_key_dat), .busy(v16_busy));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clr = 1'b0; st_req_valid = 1'b0; key_req_valid = 1'b0; v_st_valid = 1'b0;
    st_data = '0; key_word = '0;
    #3;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (st_resp_valid !== 1'b0 || key_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b%b exp=00", st_resp_valid, key_resp_valid); end
    checks++; if (st_resp_data !== ALL00) begin failures++; $display("FAIL reset_st_data got=%h exp=0", st_resp_data); end
    checks++; if (key_resp_word !== 32'h0) begin failures++; $display("FAIL reset_key_word got=%h exp=0", key_resp_word); end
    tick();
    tick();
    rst_n = 1'b1;
    st_req_valid = 1'b1; key_req_valid = 1'b1;
    #1;
    checks++; if (key_req_ready !== 1'b1 || st_req_ready !== 1'b0) begin failures++; $display("FAIL reset_first_grant got key=%b st=%b exp key=1 st=0", key_req_ready, st_req_ready); end
    st_req_valid = 1'b0; key_req_valid = 1'b0;
    #1;
    checks++; if (key_req_ready !== 1'b0 || st_req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_idle got key=%b st=%b exp 0 0", key_req_ready, st_req_ready); end
    tick();
  endtask

  task automatic test_state_job;
    st_data = VEC_IN; st_req_valid = 1'b1;
    #1;
    checks++; if (st_req_ready !== 1'b1) begin failures++; $display("FAIL st_job_accept got=%b exp=1", st_req_ready); end
    tick();
    st_req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      checks++; if (st_resp_valid !== (c == 5)) begin failures++; $display("FAIL st_job_valid c=%0d got=%b exp=%b", c, st_resp_valid, (c == 5)); end
      checks++; if (busy !== (c <= 5)) begin failures++; $display("FAIL st_job_busy c=%0d got=%b exp=%b", c, busy, (c <= 5)); end
      checks++; if (st_resp_data !== ((c >= 5) ? VEC_OUT : ALL00)) begin failures++; $display("FAIL st_job_data c=%0d got=%h exp=%h", c, st_resp_data, ((c >= 5) ? VEC_OUT : ALL00)); end
      tick();
    end
  endtask

  task automatic test_key_job;
    key_word = 32'hcf4f3c09; key_req_valid = 1'b1;
    #1;
    checks++; if (key_req_ready !== 1'b1) begin failures++; $display("FAIL key_job_accept got=%b exp=1", key_req_ready); end
    tick();
    key_req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++; if (key_resp_valid !== (c == 2)) begin failures++; $display("FAIL key_job_valid c=%0d got=%b exp=%b", c, key_resp_valid, (c == 2)); end
      checks++; if (st_resp_valid !== 1'b0) begin failures++; $display("FAIL key_job_st_valid c=%0d got=%b exp=0", c, st_resp_valid); end
      checks++; if (key_resp_word !== ((c >= 2) ? 32'h8a84eb01 : 32'h0)) begin failures++; $display("FAIL key_job_word c=%0d got=%h exp=%h", c, key_resp_word, ((c >= 2) ? 32'h8a84eb01 : 32'h0)); end
      checks++; if (st_resp_data !== VEC_OUT) begin failures++; $display("FAIL key_job_st_hold c=%0d got=%h exp=%h", c, st_resp_data, VEC_OUT); end
      tick();
    end
  endtask

  logic [31:0]  kin  [2];
  logic [31:0]  kexp [2];
  logic [127:0] sin  [2];
  logic [127:0] sexp [2];
  logic         order_key [4];

  task automatic test_back_to_back;
    int ki, si, g, kr, sr;
    bit done;
    kin[0] = 32'h00102030; kexp[0] = 32'h63cab704;
    kin[1] = 32'hcf4f3c09; kexp[1] = 32'h8a84eb01;
    sin[0] = ALL00;  sexp[0] = ALL63;
    sin[1] = VEC_IN; sexp[1] = VEC_OUT;
    order_key[0] = 1'b1; order_key[1] = 1'b0; order_key[2] = 1'b1; order_key[3] = 1'b0;
    do_reset();
    ki = 0; si = 0; g = 0; kr = 0; sr = 0; done = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      key_req_valid = (ki < 2); key_word = kin[(ki < 2) ? ki : 1];
      st_req_valid  = (si < 2); st_data  = sin[(si < 2) ? si : 1];
      #1;
      checks++; if (busy === 1'b1 && (st_req_ready !== 1'b0 || key_req_ready !== 1'b0)) begin failures++; $display("FAIL b2b_ready_while_busy cyc=%0d got st=%b key=%b exp 0 0", cyc, st_req_ready, key_req_ready); end
      if (st_req_ready === 1'b1 || key_req_ready === 1'b1) begin
        checks++;
        if (g >= 4 || st_req_ready === key_req_ready || key_req_ready !== order_key[(g < 4) ? g : 3]) begin
          failures++; $display("FAIL b2b_grant_order grant=%0d got key=%b st=%b exp key=%b", g, key_req_ready, st_req_ready, order_key[(g < 4) ? g : 3]);
        end
        if (key_req_ready === 1'b1) ki++; else si++;
        g++;
      end
      if (key_resp_valid === 1'b1) begin
        checks++; if (kr >= 2 || key_resp_word !== kexp[(kr < 2) ? kr : 1]) begin failures++; $display("FAIL b2b_key_resp n=%0d got=%h exp=%h", kr, key_resp_word, kexp[(kr < 2) ? kr : 1]); end
        kr++;
      end
      if (st_resp_valid === 1'b1) begin
        checks++; if (sr >= 2 || st_resp_data !== sexp[(sr < 2) ? sr : 1]) begin failures++; $display("FAIL b2b_st_resp n=%0d got=%h exp=%h", sr, st_resp_data, sexp[(sr < 2) ? sr : 1]); end
        sr++;
      end
      if (g == 4 && kr == 2 && sr == 2) done = 1'b1;
      tick();
    end
    checks++; if (!done) begin failures++; $display("FAIL b2b_timeout got grants=%0d key_resp=%0d st_resp=%0d exp 4 2 2", g, kr, sr); end
    key_req_valid = 1'b0; st_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_clr;
    clr = 1'b1; st_req_valid = 1'b1; st_data = ALLFF;
    #1;
    checks++; if (st_req_ready !== 1'b0) begin failures++; $display("FAIL clr_idle_ready got=%b exp=0", st_req_ready); end
    tick();
    clr = 1'b0; st_req_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clr_idle_busy got=%b exp=0", busy); end
    st_req_valid = 1'b1;
    #1;
    checks++; if (st_req_ready !== 1'b1) begin failures++; $display("FAIL clr_job_accept got=%b exp=1", st_req_ready); end
    tick();
    st_req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      clr = (c == 3);
      checks++; if (st_resp_valid !== 1'b0) begin failures++; $display("FAIL clr_no_resp c=%0d got=%b exp=0", c, st_resp_valid); end
      checks++; if (busy !== (c != 4)) begin failures++; $display("FAIL clr_busy c=%0d got=%b exp=%b", c, busy, (c != 4)); end
      checks++; if (st_resp_data !== VEC_OUT) begin failures++; $display("FAIL clr_data_hold c=%0d got=%h exp=%h", c, st_resp_data, VEC_OUT); end
      if (c < 4) tick();
    end
    st_req_valid = 1'b1; st_data = ALL00;
    #1;
    checks++; if (st_req_ready !== 1'b1) begin failures++; $display("FAIL clr_ready_after got=%b exp=1", st_req_ready); end
    tick();
    st_req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      checks++; if (st_resp_valid !== (c == 5)) begin failures++; $display("FAIL clr_next_valid c=%0d got=%b exp=%b", c, st_resp_valid, (c == 5)); end
      checks++; if (st_resp_data !== ((c >= 5) ? ALL63 : VEC_OUT)) begin failures++; $display("FAIL clr_next_data c=%0d got=%h exp=%h", c, st_resp_data, ((c >= 5) ? ALL63 : VEC_OUT)); end
      tick();
    end
  endtask

  task automatic test_reset_midjob;
    st_data = VEC_IN; st_req_valid = 1'b1;
    #1;
    tick();
    st_req_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || st_resp_valid !== 1'b0 || key_resp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_flags got busy=%b st=%b key=%b exp 0 0 0", busy, st_resp_valid, key_resp_valid); end
    checks++; if (st_resp_data !== ALL00 || key_resp_word !== 32'h0) begin failures++; $display("FAIL rstmid_data got st=%h key=%h exp 0 0", st_resp_data, key_resp_word); end
    checks++; if (st_req_ready !== 1'b0 || key_req_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready got st=%b key=%b exp 0 0", st_req_ready, key_req_ready); end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      checks++; if (st_resp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_no_resp c=%0d got valid=%b busy=%b exp 0 0", c, st_resp_valid, busy); end
      tick();
    end
    st_data = ALLFF; st_req_valid = 1'b1;
    #1;
    checks++; if (st_req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_accept got=%b exp=1", st_req_ready); end
    tick();
    st_req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      checks++; if (st_resp_valid !== (c == 5)) begin failures++; $display("FAIL rstmid_ff_valid c=%0d got=%b exp=%b", c, st_resp_valid, (c == 5)); end
      checks++; if (st_resp_data !== ((c >= 5) ? ALL16 : ALL00)) begin failures++; $display("FAIL rstmid_ff_data c=%0d got=%h exp=%h", c, st_resp_data, ((c >= 5) ? ALL16 : ALL00)); end
      tick();
    end
  endtask

  task automatic test_lanes;
    st_data = VEC_IN; v_st_valid = 1'b1;
    #1;
    checks++; if (v8_st_rdy !== 1'b1 || v16_st_rdy !== 1'b1) begin failures++; $display("FAIL lanes_accept got l8=%b l16=%b exp 1 1", v8_st_rdy, v16_st_rdy); end
    tick();
    v_st_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      checks++; if (v16_st_vld !== (c == 2)) begin failures++; $display("FAIL lanes16_valid c=%0d got=%b exp=%b", c, v16_st_vld, (c == 2)); end
      checks++; if (v8_st_vld !== (c == 3)) begin failures++; $display("FAIL lanes8_valid c=%0d got=%b exp=%b", c, v8_st_vld, (c == 3)); end
      checks++; if (v16_st_dat !== ((c >= 2) ? VEC_OUT : ALL00)) begin failures++; $display("FAIL lanes16_data c=%0d got=%h exp=%h", c, v16_st_dat, ((c >= 2) ? VEC_OUT : ALL00)); end
      checks++; if (v8_st_dat !== ((c >= 3) ? VEC_OUT : ALL00)) begin failures++; $display("FAIL lanes8_data c=%0d got=%h exp=%h", c, v8_st_dat, ((c >= 3) ? VEC_OUT : ALL00)); end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_state_job();
    test_key_job();
    test_back_to_back();
    test_clr();
    test_reset_midjob();
    test_lanes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
